// File: rtl/tc_sram_initiator_pkg.sv
// Shared helpers for the tc_sram requester bridge: derived widths,
// parameter sanity checks and the credit-update encoding.
package tc_sram_initiator_pkg;

  typedef enum logic [1:0] {
    CRED_HOLD = 2'd0,
    CRED_INC  = 2'd1,
    CRED_DEC  = 2'd2
  } cred_op_e;

  function automatic int unsigned calc_addr_width(input int unsigned num_words);
    int unsigned w;
    if (num_words > 32'd1) begin
      w = $clog2(num_words);
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 32'd1) / b;
  endfunction

  // Latency 0 would mean a same-cycle read, which the tracking pipe cannot model
  function automatic bit params_valid(input int unsigned latency, input int unsigned rsp_depth);
    return (latency >= 32'd1) && (rsp_depth >= 32'd1);
  endfunction

endpackage

// File: rtl/tc_sram_initiator_chk.sv
// Simulation-only protocol checks for the tc_sram requester bridge.
module tc_sram_initiator_chk #(
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned RspDepth    = 2,
  parameter int unsigned AddrWidth   = 10,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned CreditWidth = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  input logic                   sram_req,
  input logic [AddrWidth-1:0]   sram_addr,
  input logic [CreditWidth-1:0] credits,
  input logic                   fifo_push,
  input logic                   fifo_full,
  input logic                   fifo_pop,
  input logic                   fifo_empty,
  input logic                   rsp_valid,
  input logic                   rsp_ready,
  input logic [DataWidth-1:0]   rsp_rdata
);

  a_addr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sram_req |-> (32'(sram_addr) < NumWords));

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(credits) <= RspDepth);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_push |-> !fifo_full);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_pop |-> !fifo_empty);

  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

endmodule

// File: rtl/tc_sram_initiator_fifo.sv
// Synchronous response FIFO with count-based full/empty and pointer wrap
// that works for any depth, including non-powers of two.
module tc_sram_initiator_fifo
  import tc_sram_initiator_pkg::*;
#(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] wdata,
  output logic                 full,
  output logic                 empty,
  output logic [DataWidth-1:0] rdata
);

  localparam int unsigned PtrWidth = calc_addr_width(Depth);
  localparam int unsigned CntWidth = $clog2(Depth + 32'd1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 32'd1);

  logic [DataWidth-1:0] mem_r [Depth];
  logic [PtrWidth-1:0]  wptr_r;
  logic [PtrWidth-1:0]  rptr_r;
  logic [CntWidth-1:0]  cnt_r;
  logic [CntWidth-1:0]  cnt_next_s;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    logic [PtrWidth-1:0] n;
    if (p == LastPtr) begin
      n = {PtrWidth{1'b0}};
    end else begin
      n = p + PtrWidth'(32'd1);
    end
    return n;
  endfunction

  // Status flags, guarded handshakes and next occupancy
  always_comb begin
    full       = (cnt_r == CntWidth'(Depth));
    empty      = (cnt_r == {CntWidth{1'b0}});
    push_ok_s  = push & ~full;
    pop_ok_s   = pop & ~empty;
    rdata      = mem_r[rptr_r];
    cnt_next_s = cnt_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_next_s = cnt_r + CntWidth'(32'd1);
      2'b01:   cnt_next_s = cnt_r - CntWidth'(32'd1);
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= {PtrWidth{1'b0}};
      rptr_r <= {PtrWidth{1'b0}};
      cnt_r  <= {CntWidth{1'b0}};
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= {DataWidth{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= wdata;
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (pop_ok_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/tc_sram_initiator.sv
// Requester-side bridge onto one tc_sram port: passes accepted requests to
// the SRAM, tracks reads through the fixed latency and buffers their data.
module tc_sram_initiator
  import tc_sram_initiator_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 2,
  parameter int unsigned AddrWidth = calc_addr_width(NumWords),
  parameter int unsigned BeWidth   = ceil_div(DataWidth, ByteWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  if (!params_valid(Latency, RspDepth)) begin : g_param_check
    $fatal(1, "tc_sram_initiator: Latency and RspDepth must both be >= 1");
  end

  localparam int unsigned CreditWidth = $clog2(RspDepth + 32'd1);

  logic [CreditWidth-1:0] credits_r;
  logic [CreditWidth-1:0] credits_next_s;
  logic [Latency-1:0]     rd_pipe_r;
  logic                   credit_avail_s;
  logic                   rd_accept_s;
  logic                   rsp_pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  cred_op_e               cred_op_s;

  // Credits cover reads in flight plus buffered data, so ready never sees rsp_ready_i
  always_comb begin
    credit_avail_s = (credits_r < CreditWidth'(RspDepth));
    req_ready_o    = rst_ni & (req_we_i | credit_avail_s);
    sram_req_o     = req_valid_i & rst_ni & (req_we_i | credit_avail_s);
    sram_we_o      = req_we_i;
    sram_addr_o    = req_addr_i;
    sram_wdata_o   = req_wdata_i;
    if (req_we_i) begin
      sram_be_o = req_be_i;
    end else begin
      sram_be_o = {BeWidth{1'b1}};
    end
    rd_accept_s = sram_req_o & ~sram_we_o;
    rsp_valid_o = ~fifo_empty_s;
    rsp_pop_s   = rsp_valid_o & rsp_ready_i;
  end

  // Credit update: a simultaneous accept and pop cancel out
  always_comb begin
    cred_op_s      = CRED_HOLD;
    credits_next_s = credits_r;
    case ({rd_accept_s, rsp_pop_s})
      2'b10:   cred_op_s = CRED_INC;
      2'b01:   cred_op_s = CRED_DEC;
      default: cred_op_s = CRED_HOLD;
    endcase
    case (cred_op_s)
      CRED_INC: credits_next_s = credits_r + CreditWidth'(32'd1);
      CRED_DEC: credits_next_s = credits_r - CreditWidth'(32'd1);
      default:  credits_next_s = credits_r;
    endcase
  end

  // Credit counter and read-tracking shift register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_r <= {CreditWidth{1'b0}};
      rd_pipe_r <= {Latency{1'b0}};
    end else begin
      credits_r    <= credits_next_s;
      rd_pipe_r[0] <= rd_accept_s;
      for (int i = 1; i < Latency; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  tc_sram_initiator_fifo #(
    .Depth     (RspDepth),
    .DataWidth (DataWidth)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (rd_pipe_r[Latency-1]),
    .pop    (rsp_pop_s),
    .wdata  (sram_rdata_i),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .rdata  (rsp_rdata_o)
  );

  tc_sram_initiator_chk #(
    .NumWords    (NumWords),
    .RspDepth    (RspDepth),
    .AddrWidth   (AddrWidth),
    .DataWidth   (DataWidth),
    .CreditWidth (CreditWidth)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sram_req   (sram_req_o),
    .sram_addr  (sram_addr_o),
    .credits    (credits_r),
    .fifo_push  (rd_pipe_r[Latency-1]),
    .fifo_full  (fifo_full_s),
    .fifo_pop   (rsp_pop_s),
    .fifo_empty (fifo_empty_s),
    .rsp_valid  (rsp_valid_o),
    .rsp_ready  (rsp_ready_i),
    .rsp_rdata  (rsp_rdata_o)
  );

endmodule
